shared_reg_arbiter: RTL and testbench

SHARED_REG_ARBITER -- requirements
Module: shared_reg_arbiter

---
 rtl/shared_reg_pkg.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/shared_reg_dreg.sv | 24 ++
 rtl/shared_reg_arbiter.sv | 96 +++++++++
 tb/tb_shared_reg_arbiter.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/shared_reg_pkg.sv
// Shared types and default sizes for the shared-register arbiter.
package shared_reg_pkg;

  localparam int unsigned N_REQ_DEF = 4;
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned CNT_W     = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select: first set req bit scanning upward from ptr, wrapping.
module rr_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] winner,
  output logic             valid
);

  logic             found;
  logic [PTR_W-1:0] idx;

  // Scan N_REQ positions starting at ptr; the first hit wins.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = PTR_W'((32'(ptr) + k) % N_REQ);
      if (!found && req[idx]) begin
        winner[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/shared_reg_dreg.sv
// WIDTH-bit D-register holding q and its complement, async active-low clear.
module shared_reg_dreg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  // Load d and ~d together so qbar is always the exact complement of q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q    <= '0;
      qbar <= '1;
    end else if (en) begin
      q    <= d;
      qbar <= ~d;
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting one requester per cycle write access to a shared register.
module shared_reg_arbiter
  import shared_reg_pkg::*;
#(
  parameter int unsigned N_REQ = N_REQ_DEF,
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       q,
  output logic [WIDTH-1:0]       qbar,
  output logic                   busy,
  output logic [CNT_W-1:0]       wr_count
);

  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  state_t           state;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] gnt_idx_c;
  logic [PTR_W-1:0] arb_ptr_c;
  logic [WIDTH-1:0] wsel_c;
  logic [N_REQ-1:0] pick_c;
  logic             pick_valid_c;
  logic             wr_en_c;

  // Decode the granted index and mux out that requester's write data.
  always_comb begin
    gnt_idx_c = '0;
    wsel_c    = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt[i]) begin
        gnt_idx_c = PTR_W'(i);
        wsel_c    = wdata[i*WIDTH +: WIDTH];
      end
    end
  end

  // A write in flight moves priority to the requester after the current winner.
  always_comb begin
    arb_ptr_c = ptr;
    if (state == WRITE) begin
      arb_ptr_c = PTR_W'((32'(gnt_idx_c) + 32'd1) % N_REQ);
    end
  end

  assign wr_en_c = (state == WRITE);
  assign busy    = (state == WRITE);

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .req    (req),
    .ptr    (arb_ptr_c),
    .winner (pick_c),
    .valid  (pick_valid_c)
  );

  shared_reg_dreg #(
    .WIDTH (WIDTH)
  ) u_dreg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wr_en_c),
    .d     (wsel_c),
    .q     (q),
    .qbar  (qbar)
  );

  // FSM, grant register, round-robin pointer and completed-write counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gnt      <= '0;
      ptr      <= '0;
      wr_count <= '0;
    end else begin
      if (state == WRITE) begin
        ptr      <= arb_ptr_c;
        wr_count <= wr_count + CNT_W'(1);
      end
      if (pick_valid_c) begin
        state <= WRITE;
        gnt   <= pick_c;
      end else begin
        state <= IDLE;
        gnt   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter with a transaction-level reference model.
module tb_shared_reg_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;

  logic            clk;
  logic            rst_n;
  logic [NR-1:0]   req;
  logic [NR*W-1:0] wdata;
  logic [NR-1:0]   gnt;
  logic [W-1:0]    q;
  logic [W-1:0]    qbar;
  logic            busy;
  logic [7:0]      wr_count;

  int checks;
  int failures;

  // Reference model: granted requester index (-1 = none), pointer, register, count.
  int         m_gnt;
  int         m_ptr;
  logic [7:0] m_q;
  logic [7:0] m_cnt;

  shared_reg_arbiter #(.N_REQ(NR), .WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .wdata    (wdata),
    .gnt      (gnt),
    .q        (q),
    .qbar     (qbar),
    .busy     (busy),
    .wr_count (wr_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [NR-1:0] m_gnt_vec();
    logic [NR-1:0] v;
    v = '0;
    if (m_gnt >= 0) v[m_gnt] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_gnt = -1;
    m_ptr = 0;
    m_q   = 8'h00;
    m_cnt = 8'h00;
  endtask

  // One rising edge as seen by the model: finish pending write, then arbitrate.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      if (m_gnt >= 0) begin
        m_q   = wdata[m_gnt*W +: W];
        m_cnt = m_cnt + 8'd1;
        m_ptr = (m_gnt + 1) % NR;
      end
      m_gnt = -1;
      for (int k = 0; k < NR; k++) begin
        int j;
        j = (m_ptr + k) % NR;
        if (m_gnt < 0 && req[j]) m_gnt = j;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic apply_reset(input logic [NR-1:0] req_hold);
    @(negedge clk);
    rst_n = 1'b0;
    req   = req_hold;
    wdata = '0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset('0);
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL reset_q got=%h exp=00", q); end
    checks++; if (qbar !== 8'hFF) begin failures++; $display("FAIL reset_qbar got=%h exp=ff", qbar); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (wr_count !== 8'h00) begin failures++; $display("FAIL reset_cnt got=%h exp=00", wr_count); end
  endtask

  task automatic test_single_write();
    apply_reset('0);
    wdata = {NR*W{1'b1}};
    wdata[2*W +: W] = 8'hA5;
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy got=%b exp=1", busy); end
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL single_q_early got=%h exp=00", q); end
    req = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_gnt_off got=%b exp=0000", gnt); end
    checks++; if (q !== 8'hA5) begin failures++; $display("FAIL single_q got=%h exp=a5", q); end
    checks++; if (qbar !== 8'h5A) begin failures++; $display("FAIL single_qbar got=%h exp=5a", qbar); end
    checks++; if (wr_count !== 8'h01) begin failures++; $display("FAIL single_cnt got=%h exp=01", wr_count); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", busy); end
  endtask

  task automatic test_fairness();
    logic [NR-1:0] exp;
    apply_reset(4'b1111);
    for (int i = 0; i < 5; i++) begin
      tick();
      exp = '0;
      exp[i % NR] = 1'b1;
      checks++; if (gnt !== exp) begin failures++; $display("FAIL fair_gnt cyc=%0d got=%b exp=%b", i, gnt, exp); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL fair_busy cyc=%0d got=%b exp=1", i, busy); end
    end
    req = '0;
    tick();
    checks++; if (wr_count !== 8'd5) begin failures++; $display("FAIL fair_cnt got=%0d exp=5", wr_count); end
  endtask

  task automatic test_simultaneous();
    apply_reset('0);
    wdata = 32'h7E_11_22_33;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    tick();
    req = 4'b1010;
    tick();
    checks++; if (gnt !== 4'b1000) begin failures++; $display("FAIL simul_first got=%b exp=1000", gnt); end
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL simul_second got=%b exp=0010", gnt); end
    checks++; if (q !== 8'h7E) begin failures++; $display("FAIL simul_q3 got=%h exp=7e", q); end
    req = 4'b0000;
    tick();
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL simul_idle gnt=%b busy=%b exp=0000/0", gnt, busy); end
    checks++; if (q !== 8'h22) begin failures++; $display("FAIL simul_q1 got=%h exp=22", q); end
  endtask

  task automatic test_reset_during_write();
    apply_reset('0);
    wdata = 32'h55_66_3C_99;
    req = 4'b0010;
    tick();
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL rstw_gnt got=%b exp=0010", gnt); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (q !== 8'h00 || qbar !== 8'hFF) begin failures++; $display("FAIL rstw_q got=%h/%h exp=00/ff", q, qbar); end
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || wr_count !== 8'h00) begin failures++; $display("FAIL rstw_state gnt=%b busy=%b cnt=%h exp=0000/0/00", gnt, busy, wr_count); end
    req = 4'b0011;
    #1;
    rst_n = 1'b1;
    tick();
    checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL rstw_next got=%b exp=0001", gnt); end
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL rstw_q_hold got=%h exp=00", q); end
    req = 4'b0000;
    tick();
    checks++; if (q !== 8'h99 || wr_count !== 8'h01) begin failures++; $display("FAIL rstw_after q=%h cnt=%h exp=99/01", q, wr_count); end
  endtask

  task automatic test_random();
    apply_reset('0);
    for (int i = 0; i < 400; i++) begin
      req   = NR'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) req = '0;
      wdata = $urandom;
      tick();
      checks++;
      if (gnt !== m_gnt_vec() || busy !== (m_gnt >= 0) || q !== m_q || qbar !== ~m_q || wr_count !== m_cnt) begin
        failures++;
        $display("FAIL rand cyc=%0d gnt=%b/%b busy=%b q=%h/%h qbar=%h cnt=%h/%h", i, gnt, m_gnt_vec(), busy, q, m_q, qbar, wr_count, m_cnt);
      end
      checks++; if ($countones(gnt) > 1) begin failures++; $display("FAIL rand_onehot cyc=%0d got=%b", i, gnt); end
    end
  endtask

  task automatic test_async_reset();
    req   = 4'b1111;
    wdata = $urandom;
    tick();
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (q !== 8'h00) begin failures++; $display("FAIL async_q got=%h exp=00", q); end
    checks++; if (qbar !== 8'hFF) begin failures++; $display("FAIL async_qbar got=%h exp=ff", qbar); end
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin failures++; $display("FAIL async_gnt gnt=%b busy=%b exp=0000/0", gnt, busy); end
    checks++; if (wr_count !== 8'h00) begin failures++; $display("FAIL async_cnt got=%h exp=00", wr_count); end
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap();
    logic [7:0] last;
    int k;
    apply_reset('0);
    last = 8'h00;
    for (int i = 0; i < 256; i++) begin
      k     = $urandom_range(0, NR-1);
      req   = '0;
      req[k] = 1'b1;
      wdata = $urandom;
      last  = wdata[k*W +: W];
      tick();
    end
    req = '0;
    tick();
    checks++; if (wr_count !== 8'h00) begin failures++; $display("FAIL wrap_cnt got=%h exp=00", wr_count); end
    checks++; if (q !== last) begin failures++; $display("FAIL wrap_q got=%h exp=%h", q, last); end
    checks++; if (m_cnt !== wr_count || m_q !== q) begin failures++; $display("FAIL wrap_model cnt=%h/%h q=%h/%h", wr_count, m_cnt, q, m_q); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    req      = '0;
    wdata    = '0;
    model_reset();
    test_reset();
    test_single_write();
    test_fairness();
    test_simultaneous();
    test_reset_during_write();
    test_random();
    test_async_reset();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
